uart_cmd_link: RTL and testbench

Byte-to-command framing stage between the UART transceiver and the digital core. Assembles three received UART bytes into the 24-bit host command (`cmd` / `cmd_rdy` / `clr_cmd_rdy`). Serialises the core's single-byte responses (`resp_data` / `send_resp` / `resp_sent`) onto the UART transmitter. Discards partial frames after an inter-byte timeout so the link resynchronises after a host glitch.

---
 rtl/uart_cmd_link.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_link.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_link.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_link
// Description : Byte-to-command framing between a UART transceiver and the
//               digital core. Packs three received bytes into a 24-bit
//               command, serialises single-byte responses onto the UART
//               transmitter, and drops partial frames after an inter-byte
//               timeout so the link resynchronises after a host glitch.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_link #(
    parameter int TIMEOUT = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        frame_err
);

    // Receive-side states: waiting for byte 0/1/2, then holding the command.
    localparam logic [1:0] c_rx_b0   = 2'd0;
    localparam logic [1:0] c_rx_b1   = 2'd1;
    localparam logic [1:0] c_rx_b2   = 2'd2;
    localparam logic [1:0] c_rx_hold = 2'd3;

    localparam logic c_tx_idle = 1'b0;
    localparam logic c_tx_busy = 1'b1;

    // The counter never has to hold TIMEOUT itself, only TIMEOUT-1.
    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [1:0]         r_rx_state;
    logic [1:0]         w_rx_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [15:0]        r_stage;
    logic               w_rx_valid;
    logic               w_capture;
    logic               w_timeout;

    logic               r_tx_state;
    logic               w_tx_state_nxt;
    logic               w_tx_accept;
    logic               w_tx_finish;

    // A byte is only eligible when it is not the one being consumed right now.
    assign w_rx_valid = rx_rdy && !clr_rx_rdy;

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= c_rx_b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    // RX next state: capture beats timeout; HOLD backpressures the receiver.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_capture      = 1'b0;
        w_timeout      = 1'b0;
        case (r_rx_state)
            c_rx_b0: begin
                if (w_rx_valid) begin
                    w_capture      = 1'b1;
                    w_rx_state_nxt = c_rx_b1;
                end
            end
            c_rx_b1, c_rx_b2: begin
                if (w_rx_valid) begin
                    w_capture      = 1'b1;
                    w_rx_state_nxt = (r_rx_state == c_rx_b1) ? c_rx_b2 : c_rx_hold;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout      = 1'b1;
                    w_rx_state_nxt = c_rx_b0;
                end
            end
            c_rx_hold: begin
                if (clr_cmd_rdy) begin
                    w_rx_state_nxt = c_rx_b0;
                end
            end
            default: begin
                w_rx_state_nxt = c_rx_b0;
            end
        endcase
    end

    // RX datapath: byte staging, command output, timeout counter and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_stage    <= '0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clr_rx_rdy <= w_capture;
            frame_err  <= w_timeout;

            if (w_capture || w_timeout ||
                !((r_rx_state == c_rx_b1) || (r_rx_state == c_rx_b2))) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_stage <= '0;
            end else if (w_capture && (r_rx_state == c_rx_b0)) begin
                r_stage[15:8] <= rx_data;
            end else if (w_capture && (r_rx_state == c_rx_b1)) begin
                r_stage[7:0] <= rx_data;
            end

            if (w_capture && (r_rx_state == c_rx_b2)) begin
                cmd     <= {r_stage, rx_data};
                cmd_rdy <= 1'b1;
            end else if ((r_rx_state == c_rx_hold) && clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // TX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= c_tx_idle;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    // TX next state: requests while busy and completions while idle are dropped.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_accept    = 1'b0;
        w_tx_finish    = 1'b0;
        case (r_tx_state)
            c_tx_idle: begin
                if (send_resp) begin
                    w_tx_accept    = 1'b1;
                    w_tx_state_nxt = c_tx_busy;
                end
            end
            c_tx_busy: begin
                if (tx_done) begin
                    w_tx_finish    = 1'b1;
                    w_tx_state_nxt = c_tx_idle;
                end
            end
            default: begin
                w_tx_state_nxt = c_tx_idle;
            end
        endcase
    end

    // TX datapath: latch the response byte and generate the handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data   <= '0;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= w_tx_accept;
            resp_sent <= w_tx_finish;
            if (w_tx_accept) begin
                tx_data <= resp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_link
// Description : Self-checking bench for uart_cmd_link. A frame-level model
//               predicts capture edges, commands and timeout discards from
//               the inter-byte spacing; the TX path runs concurrently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_link;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic        frame_err;

    uart_cmd_link #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_data   (resp_data),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ferr_cnt = 0;

    // Edge counter and frame_err pulse counter (sampled pre-update at each edge).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    // Frame model state.
    int          pos     = 0;
    int          last_e  = 0;
    logic [7:0]  frm [3];
    logic [23:0] exp_cmd = 24'h0;
    int          exp_ferr = 0;
    bit          in_hold = 1'b0;
    bit          at_clr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // gap >= 0 : drop rx_rdy, idle gap+1 cycles, present byte
    // gap == -1: swap in the next byte while the previous one is being consumed
    // gap == -2: byte already pending and eligible at the next edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int e;
        if (gap >= 0) begin
            rx_rdy = 1'b0;
            repeat (gap + 1) @(negedge clk);
            e = cyc + 1;
        end else if (gap == -1) begin
            e = cyc + 2;
        end else begin
            e = cyc + 1;
        end
        rx_data = b;
        rx_rdy  = 1'b1;
        if (gap == -1) begin
            @(negedge clk);
            check_eq("ignored_during_clr", clr_rx_rdy, 0);
        end
        @(negedge clk);
        check_eq("consume", clr_rx_rdy, 1);
        if (pos > 0 && (e - last_e) > TIMEOUT) begin
            exp_ferr++;
            pos = 0;
        end
        frm[pos] = b;
        pos++;
        last_e = e;
        if (pos == 3) begin
            exp_cmd = {frm[0], frm[1], frm[2]};
            pos     = 0;
            in_hold = 1'b1;
        end
        check_eq("cmd", cmd, exp_cmd);
        check_eq("cmd_rdy", cmd_rdy, in_hold);
        check_eq("frame_err_count", ferr_cnt, exp_ferr);
        at_clr = 1'b1;
    endtask

    // Sit in HOLD (optionally with a byte pending), then release the command.
    task automatic hold_release(input int wait_n, input bit pend, input logic [7:0] pb);
        rx_rdy  = pend;
        rx_data = pb;
        repeat (wait_n) begin
            @(negedge clk);
            check_eq("hold_no_consume", clr_rx_rdy, 0);
            check_eq("hold_cmd", cmd, exp_cmd);
            check_eq("hold_cmd_rdy", cmd_rdy, 1);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check_eq("release_cmd_rdy", cmd_rdy, 0);
        check_eq("release_no_early_capture", clr_rx_rdy, 0);
        in_hold = 1'b0;
        at_clr  = 1'b0;
        if (pend) send_byte(pb, -2);
    endtask

    // Let a partial frame expire so the model and DUT are both back at byte 0.
    task automatic flush_partial();
        if (pos > 0) begin
            rx_rdy = 1'b0;
            repeat (TIMEOUT + 2) @(negedge clk);
            exp_ferr++;
            pos    = 0;
            at_clr = 1'b0;
            check_eq("flush_frame_err", ferr_cnt, exp_ferr);
        end
    endtask

    task automatic tx_txn(input logic [7:0] d, input bit extra, input logic [7:0] d2, input int dly);
        resp_data = d;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check_eq("trmt", trmt, 1);
        check_eq("tx_data", tx_data, d);
        if (extra) begin
            resp_data = d2;
            send_resp = 1'b1;
        end
        @(negedge clk);
        send_resp = 1'b0;
        check_eq("trmt_single", trmt, 0);
        check_eq("tx_data_busy", tx_data, d);
        repeat (dly) begin
            @(negedge clk);
            check_eq("no_early_resp_sent", resp_sent, 0);
            check_eq("no_retrigger", trmt, 0);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("resp_sent", resp_sent, 1);
        @(negedge clk);
        check_eq("resp_sent_pulse", resp_sent, 0);
        check_eq("tx_data_hold", tx_data, d);
    endtask

    task automatic tx_idle_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("idle_tx_done_ignored", resp_sent, 0);
        @(negedge clk);
        check_eq("idle_tx_done_ignored2", resp_sent, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd"}, cmd, 0);
        check_eq({tag, "_cmd_rdy"}, cmd_rdy, 0);
        check_eq({tag, "_clr_rx_rdy"}, clr_rx_rdy, 0);
        check_eq({tag, "_trmt"}, trmt, 0);
        check_eq({tag, "_tx_data"}, tx_data, 0);
        check_eq({tag, "_resp_sent"}, resp_sent, 0);
        check_eq({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        int f0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, 3-cycle spacing.
        send_byte(8'h02, 1);
        send_byte(8'h13, 1);
        send_byte(8'hA5, 1);
        check_eq("tp1_cmd", cmd, 24'h0213A5);
        check_eq("tp1_no_ferr", ferr_cnt, 0);

        // Backpressure in HOLD, pending byte starts the next frame.
        hold_release(10, 1'b1, 8'h55);
        send_byte(8'h66, -1);
        send_byte(8'h77, 0);
        check_eq("tp2_cmd", cmd, 24'h556677);
        hold_release(0, 1'b0, 8'h00);

        // Partial frame discarded after idling.
        f0 = ferr_cnt;
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'hAA, 20);
        check_eq("tp3_one_ferr", ferr_cnt, f0 + 1);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        check_eq("tp3_cmd", cmd, 24'hAABBCC);
        hold_release(2, 1'b0, 8'h00);

        // Second byte lands exactly on the timeout edge.
        f0 = ferr_cnt;
        send_byte(8'h10, 1);
        send_byte(8'h20, TIMEOUT - 2);
        send_byte(8'h30, 1);
        check_eq("tp4_cmd", cmd, 24'h102030);
        check_eq("tp4_no_ferr", ferr_cnt, f0);
        hold_release(1, 1'b0, 8'h00);

        // Response path with a dropped request while busy.
        tx_txn(8'hA5, 1'b1, 8'h0F, 3);
        tx_idle_done();

        // Randomised traffic on both paths at once.
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    int r;
                    int g;
                    bit p;
                    r = int'($urandom_range(0, 9));
                    if (r < 5)      g = int'($urandom_range(0, 3));
                    else if (r < 7) g = -1;
                    else            g = int'($urandom_range(TIMEOUT - 3, TIMEOUT + 1));
                    if (!at_clr && g == -1) g = 0;
                    send_byte(8'($urandom), g);
                    if (in_hold) begin
                        p = 1'($urandom_range(0, 1));
                        hold_release(int'($urandom_range(0, 4)), p, 8'($urandom));
                    end
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    if ($urandom_range(0, 3) == 0) tx_idle_done();
                    tx_txn(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                           int'($urandom_range(0, 6)));
                end
            end
        join

        // Reset mid-frame and mid-transmit.
        flush_partial();
        send_byte(8'h77, 1);
        send_byte(8'h88, 1);
        rx_rdy    = 1'b0;
        resp_data = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check_eq("pre_reset_trmt", trmt, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        pos     = 0;
        exp_cmd = 24'h0;
        in_hold = 1'b0;
        at_clr  = 1'b0;
        tx_idle_done();
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        check_eq("post_reset_cmd", cmd, 24'h112233);
        hold_release(1, 1'b0, 8'h00);
        tx_txn(8'hC3, 1'b0, 8'h00, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
